// File: rtl/cpu_types_pkg.sv
// Shared types for the decode/control stage: ALU operations, opcode and
// funct encodings, the registered control bundle and the halt FSM states.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9
    } aluop_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B,
        OP_LL    = 6'h30, OP_SC    = 6'h38, OP_HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08,
        FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22,
        FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
        FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    // All-zero value of this struct is the bubble bundle.
    typedef struct packed {
        logic   j;
        logic   jr;
        logic   jal;
        logic   beq;
        logic   bne;
        logic   halt;
        logic   lui;
        logic   regdst;
        logic   alusrc;
        logic   memtoreg;
        logic   regwrite;
        logic   extop;
        logic   shiftop;
        aluop_t aluop;
        logic   dren;
        logic   dwen;
        logic   datomic;
    } ctrl_bundle_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } halt_state_t;

endpackage

// File: rtl/decode_ctrl_stage_link_reservation.sv
// LL/SC link reservation: one reserved address, cleared by SC or by a
// matching snoop on any channel. Comparison ignores the LINK_LSB low bits.
module link_reservation #(
    parameter int WORD_W    = 32,
    parameter int NUM_SNOOP = 1,
    parameter int LINK_LSB  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WORD_W-1:0]           mem_addr_i,
    input  logic                        ll_commit_i,
    input  logic                        sc_commit_i,
    input  logic [NUM_SNOOP-1:0]        snoop_valid_i,
    input  logic [NUM_SNOOP*WORD_W-1:0] snoop_addr_i,
    output logic                        link_valid_o,
    output logic [WORD_W-1:0]           link_addr_o,
    output logic                        sc_success_o
);

    logic              link_valid_q, link_valid_d;
    logic [WORD_W-1:0] link_addr_q, link_addr_d;
    logic              snoop_hit;
    logic              unused_snoop_bits;

    // Low snoop address bits never take part in the compare.
    assign unused_snoop_bits = ^snoop_addr_i;

    // Any valid snoop channel hitting the reserved line.
    always_comb begin
        snoop_hit = 1'b0;
        for (int k = 0; k < NUM_SNOOP; k++) begin
            if (snoop_valid_i[k] &&
                snoop_addr_i[k*WORD_W+LINK_LSB +: WORD_W-LINK_LSB] ==
                link_addr_q[WORD_W-1:LINK_LSB])
                snoop_hit = 1'b1;
        end
    end

    // SC result uses the pre-edge link, so same-cycle LL/snoop cannot affect it.
    assign sc_success_o = sc_commit_i && link_valid_q &&
                          (link_addr_q[WORD_W-1:LINK_LSB] == mem_addr_i[WORD_W-1:LINK_LSB]);

    // Next reservation: LL wins over SC and snoop invalidation.
    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (ll_commit_i) begin
            link_valid_d = 1'b1;
            link_addr_d  = mem_addr_i;
        end else if (sc_commit_i || snoop_hit) begin
            link_valid_d = 1'b0;
        end
    end

    // Reservation register.
    always_ff @(posedge clk) begin
        if (rst) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    assign link_valid_o = link_valid_q;
    assign link_addr_o  = link_addr_q;

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered main decoder between IF/ID and ID/EX with stall/flush, a sticky
// halt FSM and the LL/SC link reservation. Optional macro
// DECODE_ILLEGAL_TRAP_EN adds illegal_o for unknown encodings.
// Handshake: flush_i squashes the output register on the same edge (even
// when stalled); stall_i holds it; otherwise the decoded word is loaded.
module decode_ctrl_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_SNOOP = 1,
    parameter int LINK_LSB  = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [WORD_W-1:0]           instr_i,
    input  logic                        instr_valid_i,
    input  logic                        stall_i,
    input  logic                        flush_i,
    output logic                        valid_o,
    output logic                        j_o,
    output logic                        jr_o,
    output logic                        jal_o,
    output logic                        beq_o,
    output logic                        bne_o,
    output logic                        halt_o,
    output logic                        lui_o,
    output logic                        regdst_o,
    output logic                        alusrc_o,
    output logic                        memtoreg_o,
    output logic                        regwrite_o,
    output logic                        extop_o,
    output logic                        shiftop_o,
    output aluop_t                      aluop_o,
    output logic                        dren_o,
    output logic                        dwen_o,
    output logic                        datomic_o,
    input  logic [WORD_W-1:0]           mem_addr_i,
    input  logic                        ll_commit_i,
    input  logic                        sc_commit_i,
    input  logic [NUM_SNOOP-1:0]        snoop_valid_i,
    input  logic [NUM_SNOOP*WORD_W-1:0] snoop_addr_i,
    output logic                        link_valid_o,
    output logic [WORD_W-1:0]           link_addr_o,
    output logic                        sc_success_o,
    output logic                        dbg_halted_o
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic                        illegal_o
`endif
);

    function automatic ctrl_bundle_t decode_instr(input logic [5:0] op,
                                                  input logic [5:0] fn,
                                                  output logic known);
        ctrl_bundle_t c;
        c     = '0;
        known = 1'b1;
        case (op)
            OP_RTYPE: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                case (fn)
                    FN_SLL:          begin c.shiftop = 1'b1; c.aluop = ALU_SLL; end
                    FN_SRL:          begin c.shiftop = 1'b1; c.aluop = ALU_SRL; end
                    FN_JR:           begin c.jr = 1'b1; c.regdst = 1'b0; c.regwrite = 1'b0; end
                    FN_ADD, FN_ADDU: c.aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: c.aluop = ALU_SUB;
                    FN_AND:          c.aluop = ALU_AND;
                    FN_OR:           c.aluop = ALU_OR;
                    FN_XOR:          c.aluop = ALU_XOR;
                    FN_NOR:          c.aluop = ALU_NOR;
                    FN_SLT:          c.aluop = ALU_SLT;
                    FN_SLTU:         c.aluop = ALU_SLTU;
                    default:         known = 1'b0;
                endcase
            end
            OP_J:              c.j = 1'b1;
            OP_JAL:            begin c.jal = 1'b1; c.regwrite = 1'b1; end
            OP_BEQ:            begin c.beq = 1'b1; c.extop = 1'b1; c.aluop = ALU_SUB; end
            OP_BNE:            begin c.bne = 1'b1; c.extop = 1'b1; c.aluop = ALU_SUB; end
            OP_LUI:            begin c.lui = 1'b1; c.regwrite = 1'b1; c.alusrc = 1'b1; end
            OP_ADDI, OP_ADDIU: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.extop = 1'b1; end
            OP_SLTI:           begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.extop = 1'b1; c.aluop = ALU_SLT; end
            OP_SLTIU:          begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.extop = 1'b1; c.aluop = ALU_SLTU; end
            OP_ANDI:           begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALU_AND; end
            OP_ORI:            begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALU_OR; end
            OP_XORI:           begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALU_XOR; end
            OP_LW, OP_LL: begin
                c.dren = 1'b1; c.alusrc = 1'b1; c.extop = 1'b1;
                c.memtoreg = 1'b1; c.regwrite = 1'b1;
                c.datomic = (op == OP_LL);
            end
            OP_SW:             begin c.dwen = 1'b1; c.alusrc = 1'b1; c.extop = 1'b1; end
            OP_SC: begin
                c.dwen = 1'b1; c.alusrc = 1'b1; c.extop = 1'b1;
                c.datomic = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1;
            end
            OP_HALT:           c.halt = 1'b1;
            default:           known = 1'b0;
        endcase
        if (!known) c = '0;
        return c;
    endfunction

    ctrl_bundle_t bundle_q, bundle_d, dec;
    logic         valid_q, valid_d;
    logic         known;
    logic         load_valid;
    halt_state_t  state_q, state_d;
    logic         unused_instr_bits;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic         illegal_q, illegal_d;
`endif

    // Only opcode and funct steer the control bundle.
    assign unused_instr_bits = ^instr_i;

    // Next output register / FSM state with priority flush > stall > load; HALTED overrides all.
    always_comb begin
        dec        = decode_instr(instr_i[31:26], instr_i[5:0], known);
        load_valid = instr_valid_i && known;
        state_d    = state_q;
        bundle_d   = bundle_q;
        valid_d    = valid_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_d  = illegal_q;
`endif
        if (state_q == HALTED || (bundle_q.halt && valid_q && !stall_i)) begin
            state_d       = HALTED;
            bundle_d      = '0;
            bundle_d.halt = 1'b1;
            valid_d       = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_d     = 1'b0;
`endif
        end else if (flush_i) begin
            bundle_d  = '0;
            valid_d   = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_d = 1'b0;
`endif
        end else if (!stall_i) begin
            bundle_d  = load_valid ? dec : '0;
            valid_d   = load_valid;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_d = instr_valid_i && !known;
`endif
        end
    end

    // Output register and halt FSM state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= RUN;
            bundle_q  <= '0;
            valid_q   <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bundle_q  <= bundle_d;
            valid_q   <= valid_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign valid_o      = valid_q;
    assign j_o          = bundle_q.j;
    assign jr_o         = bundle_q.jr;
    assign jal_o        = bundle_q.jal;
    assign beq_o        = bundle_q.beq;
    assign bne_o        = bundle_q.bne;
    assign halt_o       = bundle_q.halt;
    assign lui_o        = bundle_q.lui;
    assign regdst_o     = bundle_q.regdst;
    assign alusrc_o     = bundle_q.alusrc;
    assign memtoreg_o   = bundle_q.memtoreg;
    assign regwrite_o   = bundle_q.regwrite;
    assign extop_o      = bundle_q.extop;
    assign shiftop_o    = bundle_q.shiftop;
    assign aluop_o      = bundle_q.aluop;
    assign dren_o       = bundle_q.dren;
    assign dwen_o       = bundle_q.dwen;
    assign datomic_o    = bundle_q.datomic;
    assign dbg_halted_o = (state_q == HALTED);
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal_o    = illegal_q;
`endif

    link_reservation #(
        .WORD_W    (WORD_W),
        .NUM_SNOOP (NUM_SNOOP),
        .LINK_LSB  (LINK_LSB)
    ) u_link (
        .clk           (CLK),
        .rst           (RST),
        .mem_addr_i    (mem_addr_i),
        .ll_commit_i   (ll_commit_i),
        .sc_commit_i   (sc_commit_i),
        .snoop_valid_i (snoop_valid_i),
        .snoop_addr_i  (snoop_addr_i),
        .link_valid_o  (link_valid_o),
        .link_addr_o   (link_addr_o),
        .sc_success_o  (sc_success_o)
    );

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: decode vector table, stall/flush/halt
// sequences, LL/SC reservation sequences and randomized runs against a
// rule-based reference model. Build with DECODE_ILLEGAL_TRAP_EN to also
// cover illegal_o.
module tb_decode_ctrl_stage;
  import cpu_types_pkg::*;

  localparam int WORD_W    = 32;
  localparam int NUM_SNOOP = 2;
  localparam int LINK_LSB  = 2;

  // bench-side flag encoding of the control bundle
  localparam logic [15:0] F_J        = 16'h0001;
  localparam logic [15:0] F_JR       = 16'h0002;
  localparam logic [15:0] F_JAL      = 16'h0004;
  localparam logic [15:0] F_BEQ      = 16'h0008;
  localparam logic [15:0] F_BNE      = 16'h0010;
  localparam logic [15:0] F_HALT     = 16'h0020;
  localparam logic [15:0] F_LUI      = 16'h0040;
  localparam logic [15:0] F_REGDST   = 16'h0080;
  localparam logic [15:0] F_ALUSRC   = 16'h0100;
  localparam logic [15:0] F_MEMTOREG = 16'h0200;
  localparam logic [15:0] F_REGWRITE = 16'h0400;
  localparam logic [15:0] F_EXTOP    = 16'h0800;
  localparam logic [15:0] F_SHIFTOP  = 16'h1000;
  localparam logic [15:0] F_DREN     = 16'h2000;
  localparam logic [15:0] F_DWEN     = 16'h4000;
  localparam logic [15:0] F_DATOMIC  = 16'h8000;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic [31:0] instr_i;
  logic instr_valid_i, stall_i, flush_i;
  logic valid_o, j_o, jr_o, jal_o, beq_o, bne_o, halt_o, lui_o;
  logic regdst_o, alusrc_o, memtoreg_o, regwrite_o, extop_o, shiftop_o;
  aluop_t aluop_o;
  logic dren_o, dwen_o, datomic_o;
  logic [31:0] mem_addr_i;
  logic ll_commit_i, sc_commit_i;
  logic [NUM_SNOOP-1:0] snoop_valid_i;
  logic [NUM_SNOOP*WORD_W-1:0] snoop_addr_i;
  logic link_valid_o;
  logic [31:0] link_addr_o;
  logic sc_success_o, dbg_halted_o;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_o;
`endif

  always #5 clk = ~clk;

  decode_ctrl_stage #(.WORD_W(WORD_W), .NUM_SNOOP(NUM_SNOOP), .LINK_LSB(LINK_LSB)) dut (
    .CLK(clk), .RST(rst), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o),
    .j_o(j_o), .jr_o(jr_o), .jal_o(jal_o), .beq_o(beq_o), .bne_o(bne_o),
    .halt_o(halt_o), .lui_o(lui_o), .regdst_o(regdst_o), .alusrc_o(alusrc_o),
    .memtoreg_o(memtoreg_o), .regwrite_o(regwrite_o), .extop_o(extop_o),
    .shiftop_o(shiftop_o), .aluop_o(aluop_o), .dren_o(dren_o), .dwen_o(dwen_o),
    .datomic_o(datomic_o), .mem_addr_i(mem_addr_i), .ll_commit_i(ll_commit_i),
    .sc_commit_i(sc_commit_i), .snoop_valid_i(snoop_valid_i),
    .snoop_addr_i(snoop_addr_i), .link_valid_o(link_valid_o),
    .link_addr_o(link_addr_o), .sc_success_o(sc_success_o),
    .dbg_halted_o(dbg_halted_o)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .illegal_o(illegal_o)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_flags();
    return {datomic_o, dwen_o, dren_o, shiftop_o, extop_o, regwrite_o, memtoreg_o,
            alusrc_o, regdst_o, lui_o, halt_o, bne_o, beq_o, jal_o, jr_o, j_o};
  endfunction

  // ---------------- reference model (rule based) ----------------
  function automatic void ref_decode(input logic [31:0] ins, input logic v,
                                     output logic [15:0] f, output aluop_t a,
                                     output logic ok, output logic ill);
    logic [5:0] op, fn;
    logic r_alu, shift, jr, imm_arith, imm_logic, lui, load, store, atomic, branch, jmp, jal, halt;
    op = ins[31:26];
    fn = ins[5:0];
    r_alu     = (op == 6'h00) && (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B});
    shift     = (op == 6'h00) && (fn inside {6'h00, 6'h02});
    jr        = (op == 6'h00) && (fn == 6'h08);
    imm_arith = op inside {6'h08, 6'h09, 6'h0A, 6'h0B};
    imm_logic = op inside {6'h0C, 6'h0D, 6'h0E};
    lui       = (op == 6'h0F);
    load      = op inside {6'h23, 6'h30};
    store     = op inside {6'h2B, 6'h38};
    atomic    = op inside {6'h30, 6'h38};
    branch    = op inside {6'h04, 6'h05};
    jmp       = (op == 6'h02);
    jal       = (op == 6'h03);
    halt      = (op == 6'h3F);
    ok  = v && (r_alu || shift || jr || imm_arith || imm_logic || lui || load || store || branch || jmp || jal || halt);
    ill = v && !ok;
    f = '0;
    a = ALU_ADD;
    if (!ok) return;
    if (jmp)                                 f |= F_J;
    if (jr)                                  f |= F_JR;
    if (jal)                                 f |= F_JAL;
    if (op == 6'h04)                         f |= F_BEQ;
    if (op == 6'h05)                         f |= F_BNE;
    if (halt)                                f |= F_HALT;
    if (lui)                                 f |= F_LUI;
    if (r_alu || shift)                      f |= F_REGDST;
    if (imm_arith || imm_logic || lui || load || store) f |= F_ALUSRC;
    if (load || atomic)                      f |= F_MEMTOREG;
    if (r_alu || shift || imm_arith || imm_logic || lui || load || atomic || jal) f |= F_REGWRITE;
    if (imm_arith || load || store || branch) f |= F_EXTOP;
    if (shift)                               f |= F_SHIFTOP;
    if (load)                                f |= F_DREN;
    if (store)                               f |= F_DWEN;
    if (atomic)                              f |= F_DATOMIC;
    if (op == 6'h00) begin
      case (fn)
        6'h00: a = ALU_SLL;
        6'h02: a = ALU_SRL;
        6'h22, 6'h23: a = ALU_SUB;
        6'h24: a = ALU_AND;
        6'h25: a = ALU_OR;
        6'h26: a = ALU_XOR;
        6'h27: a = ALU_NOR;
        6'h2A: a = ALU_SLT;
        6'h2B: a = ALU_SLTU;
        default: a = ALU_ADD;
      endcase
    end else if (op == 6'h0A) a = ALU_SLT;
    else if (op == 6'h0B) a = ALU_SLTU;
    else if (op == 6'h0C) a = ALU_AND;
    else if (op == 6'h0D) a = ALU_OR;
    else if (op == 6'h0E) a = ALU_XOR;
    else if (branch)      a = ALU_SUB;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_dec(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    @(negedge clk);
    instr_i = ins; instr_valid_i = v; stall_i = st; flush_i = fl;
    @(posedge clk);
    #1;
  endtask

  // applies reservation inputs before the edge; caller checks sc_success_o, then calls tick
  task automatic drive_link(input logic ll, input logic sc, input logic [31:0] addr,
                            input logic [1:0] sv, input logic [31:0] sa0, input logic [31:0] sa1);
    @(negedge clk);
    ll_commit_i = ll; sc_commit_i = sc; mem_addr_i = addr;
    snoop_valid_i = sv; snoop_addr_i = {sa1, sa0};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bundle(input string nm, input logic [15:0] f, input aluop_t a, input logic v);
    chk({nm, ".flags"}, 32'(dut_flags()), 32'(f));
    chk({nm, ".aluop"}, 32'(aluop_o), 32'(a));
    chk({nm, ".valid"}, 32'(valid_o), 32'(v));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        v;
    logic [15:0] flags;
    aluop_t      op;
    logic        ev;
    logic        ill;
  } vec_t;
  vec_t vecs[$];

  logic [5:0] op_pool [16] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                               6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h30, 6'h38};
  logic [5:0] fn_pool [13] = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
                               6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: begin r[31:26] = 6'h00; r[5:0] = fn_pool[$urandom_range(0, 12)]; end
      1, 2: r[31:26] = op_pool[$urandom_range(0, 15)];
      default: if (r[31:26] == 6'h3F) r[31:26] = 6'h13;
    endcase
    return r;
  endfunction

  // ---------------- main test ----------------
  initial begin
    logic [15:0] mf;
    aluop_t ma;
    logic mv, mill, ok, ill;
    logic m_lv;
    logic [31:0] m_la;

    rst = 1'b1; instr_i = '0; instr_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    mem_addr_i = '0; ll_commit_i = 1'b0; sc_commit_i = 1'b0;
    snoop_valid_i = '0; snoop_addr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_bundle("reset", 16'h0, ALU_ADD, 1'b0);
    chk("reset.link_valid", 32'(link_valid_o), 32'h0);
    chk("reset.link_addr", link_addr_o, 32'h0);
    chk("reset.halted", 32'(dbg_halted_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{"addi",    32'h2001FFFF, 1'b1, F_REGWRITE|F_ALUSRC|F_EXTOP, ALU_ADD, 1'b1, 1'b0});
    vecs.push_back('{"add",     32'h00221820, 1'b1, F_REGDST|F_REGWRITE, ALU_ADD, 1'b1, 1'b0});
    vecs.push_back('{"subu",    32'h00221823, 1'b1, F_REGDST|F_REGWRITE, ALU_SUB, 1'b1, 1'b0});
    vecs.push_back('{"sll",     32'h00011080, 1'b1, F_REGDST|F_REGWRITE|F_SHIFTOP, ALU_SLL, 1'b1, 1'b0});
    vecs.push_back('{"jr",      32'h03E00008, 1'b1, F_JR, ALU_ADD, 1'b1, 1'b0});
    vecs.push_back('{"sltiu",   32'h2C220005, 1'b1, F_REGWRITE|F_ALUSRC|F_EXTOP, ALU_SLTU, 1'b1, 1'b0});
    vecs.push_back('{"slti",    32'h28220005, 1'b1, F_REGWRITE|F_ALUSRC|F_EXTOP, ALU_SLT, 1'b1, 1'b0});
    vecs.push_back('{"andi",    32'h30220005, 1'b1, F_REGWRITE|F_ALUSRC, ALU_AND, 1'b1, 1'b0});
    vecs.push_back('{"lui",     32'h3C011234, 1'b1, F_LUI|F_REGWRITE|F_ALUSRC, ALU_ADD, 1'b1, 1'b0});
    vecs.push_back('{"beq",     32'h10220003, 1'b1, F_BEQ|F_EXTOP, ALU_SUB, 1'b1, 1'b0});
    vecs.push_back('{"j",       32'h08000010, 1'b1, F_J, ALU_ADD, 1'b1, 1'b0});
    vecs.push_back('{"jal",     32'h0C000010, 1'b1, F_JAL|F_REGWRITE, ALU_ADD, 1'b1, 1'b0});
    vecs.push_back('{"lw",      32'h8C220004, 1'b1, F_DREN|F_ALUSRC|F_EXTOP|F_MEMTOREG|F_REGWRITE, ALU_ADD, 1'b1, 1'b0});
    vecs.push_back('{"sw",      32'hAC220004, 1'b1, F_DWEN|F_ALUSRC|F_EXTOP, ALU_ADD, 1'b1, 1'b0});
    vecs.push_back('{"ll",      32'hC0220004, 1'b1, F_DREN|F_ALUSRC|F_EXTOP|F_MEMTOREG|F_REGWRITE|F_DATOMIC, ALU_ADD, 1'b1, 1'b0});
    vecs.push_back('{"sc",      32'hE0220004, 1'b1, F_DWEN|F_ALUSRC|F_EXTOP|F_MEMTOREG|F_REGWRITE|F_DATOMIC, ALU_ADD, 1'b1, 1'b0});
    vecs.push_back('{"bubble",  32'h2001FFFF, 1'b0, 16'h0, ALU_ADD, 1'b0, 1'b0});
    vecs.push_back('{"bad_op",  32'h4C000000, 1'b1, 16'h0, ALU_ADD, 1'b0, 1'b1});
    vecs.push_back('{"bad_fn",  32'h00000001, 1'b1, 16'h0, ALU_ADD, 1'b0, 1'b1});

    foreach (vecs[i]) begin
      drive_dec(vecs[i].instr, vecs[i].v, 1'b0, 1'b0);
      chk_bundle(vecs[i].name, vecs[i].flags, vecs[i].op, vecs[i].ev);
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk({vecs[i].name, ".illegal"}, 32'(illegal_o), 32'(vecs[i].ill));
`endif
    end

    // LW held through two stalled cycles while ORI waits, then flush beats stall
    drive_dec(32'h8C220004, 1'b1, 1'b0, 1'b0);
    chk_bundle("lw_load", F_DREN|F_ALUSRC|F_EXTOP|F_MEMTOREG|F_REGWRITE, ALU_ADD, 1'b1);
    for (int k = 0; k < 2; k++) begin
      drive_dec(32'h34220005, 1'b1, 1'b1, 1'b0);
      chk_bundle("lw_stall", F_DREN|F_ALUSRC|F_EXTOP|F_MEMTOREG|F_REGWRITE, ALU_ADD, 1'b1);
    end
    drive_dec(32'h34220005, 1'b1, 1'b1, 1'b1);
    chk_bundle("flush_stall", 16'h0, ALU_ADD, 1'b0);

    // randomized decode with stall/flush against the model
    mf = '0; ma = ALU_ADD; mv = 1'b0; mill = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ins;
      logic v, st, fl;
      logic [15:0] f;
      aluop_t a;
      ins = rand_instr();
      v   = ($urandom_range(0, 7) != 0);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      drive_dec(ins, v, st, fl);
      ref_decode(ins, v, f, a, ok, ill);
      if (fl) begin
        mf = '0; ma = ALU_ADD; mv = 1'b0; mill = 1'b0;
      end else if (!st) begin
        mf = f; ma = a; mv = ok; mill = ill;
      end
      chk_bundle("rand_dec", mf, ma, mv);
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("rand_dec.illegal", 32'(illegal_o), 32'(mill));
`endif
    end
    drive_dec(32'h0, 1'b0, 1'b0, 1'b0);

    // LL then SC to the same word
    drive_link(1'b1, 1'b0, 32'h100, 2'b00, 32'h0, 32'h0);
    tick();
    chk("ll100.link_valid", 32'(link_valid_o), 32'h1);
    chk("ll100.link_addr", link_addr_o, 32'h100);
    drive_link(1'b0, 1'b1, 32'h100, 2'b00, 32'h0, 32'h0);
    chk("sc100.success", 32'(sc_success_o), 32'h1);
    tick();
    chk("sc100.link_cleared", 32'(link_valid_o), 32'h0);
    drive_link(1'b0, 1'b1, 32'h100, 2'b00, 32'h0, 32'h0);
    chk("sc100_again.success", 32'(sc_success_o), 32'h0);
    tick();

    // snoop to another word keeps the link, snoop to the same word clears it
    drive_link(1'b1, 1'b0, 32'h200, 2'b00, 32'h0, 32'h0);
    tick();
    drive_link(1'b0, 1'b0, 32'h0, 2'b10, 32'h0, 32'h204);
    tick();
    chk("snoop204.link_valid", 32'(link_valid_o), 32'h1);
    drive_link(1'b0, 1'b0, 32'h0, 2'b10, 32'h0, 32'h203);
    tick();
    chk("snoop203.link_valid", 32'(link_valid_o), 32'h0);
    drive_link(1'b0, 1'b1, 32'h200, 2'b00, 32'h0, 32'h0);
    chk("sc200_after_snoop.success", 32'(sc_success_o), 32'h0);
    tick();

    // LL with same-cycle matching snoop: LL wins
    drive_link(1'b1, 1'b0, 32'h300, 2'b01, 32'h300, 32'h0);
    tick();
    chk("ll300_snoop.link_valid", 32'(link_valid_o), 32'h1);
    chk("ll300_snoop.link_addr", link_addr_o, 32'h300);
    // LL with SC: SC sees old link (0x300), LL installs 0x400
    drive_link(1'b1, 1'b1, 32'h400, 2'b00, 32'h0, 32'h0);
    chk("ll_sc.success_old_link", 32'(sc_success_o), 32'h0);
    tick();
    chk("ll_sc.link_valid", 32'(link_valid_o), 32'h1);
    chk("ll_sc.link_addr", link_addr_o, 32'h400);
    // SC with matching snoop still succeeds on the pre-edge link
    drive_link(1'b0, 1'b1, 32'h401, 2'b11, 32'h400, 32'h400);
    chk("sc_snoop.success", 32'(sc_success_o), 32'h1);
    tick();
    chk("sc_snoop.link_valid", 32'(link_valid_o), 32'h0);

    // randomized reservation traffic
    m_lv = 1'b0; m_la = link_addr_o;
    for (int n = 0; n < 200; n++) begin
      logic [31:0] pool [5];
      logic ll, sc;
      logic [1:0] sv;
      logic [31:0] ad, s0, s1;
      logic hit;
      pool = '{32'h100, 32'h101, 32'h104, 32'h200, 32'h203};
      ll = ($urandom_range(0, 3) == 0);
      sc = ($urandom_range(0, 3) == 0);
      sv = 2'($urandom_range(0, 3));
      ad = pool[$urandom_range(0, 4)];
      s0 = pool[$urandom_range(0, 4)];
      s1 = pool[$urandom_range(0, 4)];
      drive_link(ll, sc, ad, sv, s0, s1);
      chk("rand_link.sc_success", 32'(sc_success_o), 32'(sc && m_lv && ((m_la >> 2) == (ad >> 2))));
      hit = (sv[0] && ((s0 >> 2) == (m_la >> 2))) || (sv[1] && ((s1 >> 2) == (m_la >> 2)));
      tick();
      if (ll) begin
        m_lv = 1'b1; m_la = ad;
      end else if (sc || hit) begin
        m_lv = 1'b0;
      end
      chk("rand_link.link_valid", 32'(link_valid_o), 32'(m_lv));
      chk("rand_link.link_addr", link_addr_o, m_la);
    end

    // hold a reservation so the following reset also proves it is cleared
    drive_link(1'b1, 1'b0, 32'h500, 2'b00, 32'h0, 32'h0);
    tick();
    drive_link(1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0);

    // HALT then ADD: halt is sticky, valid drops
    drive_dec(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    chk_bundle("halt_load", F_HALT, ALU_ADD, 1'b1);
    chk("halt_load.halted", 32'(dbg_halted_o), 32'h0);
    drive_dec(32'h00221820, 1'b1, 1'b0, 1'b0);
    chk_bundle("halted", F_HALT, ALU_ADD, 1'b0);
    chk("halted.state", 32'(dbg_halted_o), 32'h1);
    for (int k = 0; k < 4; k++) begin
      drive_dec(rand_instr(), 1'b1, 1'(k == 1), 1'(k == 2));
      chk_bundle("halted_hold", F_HALT, ALU_ADD, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_bundle("rst_halt", 16'h0, ALU_ADD, 1'b0);
    chk("rst_halt.state", 32'(dbg_halted_o), 32'h0);
    chk("rst_halt.link_valid", 32'(link_valid_o), 32'h0);
    chk("rst_halt.link_addr", link_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_dec(32'h2001FFFF, 1'b1, 1'b0, 1'b0);
    chk_bundle("post_rst_addi", F_REGWRITE|F_ALUSRC|F_EXTOP, ALU_ADD, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
